// File: rtl/row_rle_compressor.sv
// rtl/row_rle_compressor.sv - sequential LSB-first run-length encoder for one feature-map row
// Raw copy is emitted with out_fail when the row does not fit the field format.
module row_rle_compressor #(
    parameter int SECTION_SIZE = 4,
    parameter int ROW_SIZE     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ROW_SIZE-1:0] in_row,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROW_SIZE-1:0] out_data,
    output logic                out_fail
);

    localparam int CW        = $clog2(ROW_SIZE + 1);
    localparam int BW        = $clog2(ROW_SIZE);
    localparam int MAX_SECTS = ROW_SIZE / SECTION_SIZE;

    localparam logic [CW-1:0] MAX_SECT = CW'(MAX_SECTS);
    localparam logic [CW-1:0] MAX_RUN  = CW'(2 ** SECTION_SIZE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(ROW_SIZE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT} state_t;

    typedef struct packed {
        logic [ROW_SIZE-1:0] acc;
        logic [CW-1:0]       idx;
        logic                fail;
    } enc_t;

    state_t              state_q, state_d;
    logic [ROW_SIZE-1:0] shift_q, shift_d;
    logic [ROW_SIZE-1:0] raw_q, raw_d;
    logic [BW-1:0]       cnt_q, cnt_d;
    logic                cur_q, cur_d;
    logic [CW-1:0]       run_q, run_d;
    enc_t                enc_q, enc_d;
    logic                last_bit;

    // Writes a finished run into the next free field; overflow of field count or length is sticky.
    function automatic enc_t close_run(input enc_t s, input logic [CW-1:0] len);
        enc_t r;
        r = s;
        if (s.idx >= MAX_SECT || len > MAX_RUN) begin
            r.fail = 1'b1;
        end
        if (s.idx < MAX_SECT) begin
            for (int k = 0; k < MAX_SECTS; k++) begin
                if (CW'(k) == s.idx) begin
                    r.acc[k*SECTION_SIZE +: SECTION_SIZE] = len[SECTION_SIZE-1:0];
                end
            end
            r.idx = s.idx + CW'(1);
        end
        return r;
    endfunction

    assign last_bit = (cnt_q == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SCAN;
            SCAN:    if (last_bit) state_d = EMIT;
            EMIT:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        out_fail  = 1'b0;
        out_data  = '0;
        if (state_q == EMIT) begin
            out_fail = enc_q.fail;
            out_data = enc_q.fail ? raw_q : enc_q.acc;
        end
    end

    always_comb begin
        shift_d = shift_q;
        raw_d   = raw_q;
        cnt_d   = cnt_q;
        cur_d   = cur_q;
        run_d   = run_q;
        enc_d   = enc_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d = in_row;
                    raw_d   = in_row;
                    cnt_d   = '0;
                    cur_d   = 1'b0;
                    run_d   = '0;
                    enc_d   = '0;
                end
            end
            SCAN: begin
                shift_d = shift_q >> 1;
                cnt_d   = cnt_q + BW'(1);
                if (shift_q[0] == cur_q) begin
                    run_d = run_q + CW'(1);
                end else begin
                    enc_d = close_run(enc_q, run_q);
                    run_d = CW'(1);
                    cur_d = ~cur_q;
                end
                // A trailing 1-run is encoded; a trailing 0-run is implied by the zero fields.
                if (last_bit && cur_d) begin
                    enc_d = close_run(enc_d, run_d);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            raw_q   <= '0;
            cnt_q   <= '0;
            cur_q   <= 1'b0;
            run_q   <= '0;
            enc_q   <= '0;
        end else begin
            shift_q <= shift_d;
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            run_q   <= run_d;
            enc_q   <= enc_d;
        end
    end

endmodule
